// File: rtl/axi4lite_wr_arb_pkg.sv
// rtl/axi4lite_wr_arb_pkg.sv - shared types, response codes and round-robin pick for the write arbiter
//
// Purpose: common definitions imported by rr_arbiter_n and axi4lite_wr_arbiter.
//   state_e     : arbiter FSM states
//   RESP_*      : AXI BRESP encodings
//   rr_pick()   : first asserted request at or above a pointer, wrapping modulo n
package axi4lite_wr_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3,
    DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Largest supported requester count; callers zero-pad req to this width.
  localparam int MAX_REQ = 8;

  // Scan n requesters starting at ptr and wrapping; returns 0 when none asserted.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [2:0] idx;
    logic       found;
    rr_pick = 3'd0;
    found   = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axi4lite_wr_arbiter_rr.sv
// rtl/axi4lite_wr_arbiter_rr.sv - round-robin pick with registered priority pointer
//
// Purpose: combinational grant among NUM_REQ requesters, priority starting at ptr_q.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (ptr_q -> 0)
//   req       : request vector to arbitrate
//   advance   : move ptr_q to one past the current gnt_idx (mod NUM_REQ)
//   gnt_idx   : index of the winning requester
//   gnt_vld   : at least one request asserted
module rr_arbiter_n
  import axi4lite_wr_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_vld
);

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [MAX_REQ-1:0] req_pad;
  logic [2:0]         pick;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req;
    pick                 = rr_pick(req_pad, 3'(ptr_q), NUM_REQ);
    gnt_idx              = IW'(pick);
    gnt_vld              = |req;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/axi4lite_wr_arbiter.sv
// rtl/axi4lite_wr_arbiter.sv - round-robin sharing of one AXI4-Lite write driver among NUM_REQ requesters
//
// Purpose: grant a requester, register its payload, pulse drv_start, wait for
// drv_done and return a one-cycle one-hot ack with the captured BRESP.
// Optional watchdog: define AXI4LITE_WR_ARB_TIMEOUT_EN to add TIMEOUT_CYC,
// the sticky timeout_err output and the DRAIN state.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req / req_addr/data/strb     : per-requester request and packed payload slices
//   ack, ack_resp                : one-cycle completion pulse and its BRESP
//   drv_start, drv_done, drv_bresp : handshake with the write driver
//   m_awaddr, m_wdata, m_wstrb   : registered payload of the current winner
//   busy                         : FSM not in IDLE
//   timeout_err                  : (macro only) sticky watchdog flag
module axi4lite_wr_arbiter
  import axi4lite_wr_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*DW-1:0]   req_data,
  input  logic [NUM_REQ*DW/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]      ack,
  output logic [1:0]              ack_resp,
  output logic                    drv_start,
  input  logic                    drv_done,
  input  logic [1:0]              drv_bresp,
  output logic [AW-1:0]           m_awaddr,
  output logic [DW-1:0]           m_wdata,
  output logic [DW/8-1:0]         m_wstrb,
  output logic                    busy
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
  , output logic                  timeout_err
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = DW / 8;

  state_e               state_q, state_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic [AW-1:0]        awaddr_q, awaddr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [SW-1:0]        wstrb_q, wstrb_d;
  logic                 drv_start_q, drv_start_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [1:0]           ack_resp_q, ack_resp_d;
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
  logic [15:0]          cnt_q, cnt_d;
  logic                 to_err_q, to_err_d;
`endif

  logic [NUM_REQ-1:0]   gnt_oh;
  logic [NUM_REQ-1:0]   arb_req;
  logic                 arb_adv;
  logic [IW-1:0]        arb_idx;
  logic                 arb_vld;

  assign gnt_oh = NUM_REQ'(1) << gnt_q;

  // Outside IDLE the arbiter only sees the latched winner, so when the pointer
  // advances it lands one past the winner, not past whoever is requesting now.
  assign arb_req = (state_q == IDLE) ? req : gnt_oh;

  rr_arbiter_n #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (arb_adv),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    drv_start_d = 1'b0;
    ack_d       = '0;
    ack_resp_d  = RESP_OKAY;
    arb_adv     = 1'b0;
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    to_err_d    = to_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d    = arb_idx;
          awaddr_d = req_addr[int'(arb_idx)*AW +: AW];
          wdata_d  = req_data[int'(arb_idx)*DW +: DW];
          wstrb_d  = req_strb[int'(arb_idx)*SW +: SW];
          state_d  = START;
        end
      end
      START: begin
        // drv_start is registered, so the pulse lands in the first WAIT cycle.
        drv_start_d = 1'b1;
        state_d     = WAIT;
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      WAIT: begin
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        if (drv_done) begin
          ack_d      = gnt_oh;
          ack_resp_d = drv_bresp;
          state_d    = ACK;
        end
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          // Answer the requester now; the driver is still owed its drv_done.
          ack_d      = gnt_oh;
          ack_resp_d = RESP_SLVERR;
          to_err_d   = 1'b1;
          arb_adv    = 1'b1;
          state_d    = DRAIN;
        end
`endif
      end
      ACK: begin
        arb_adv = 1'b1;
        state_d = IDLE;
      end
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
      DRAIN: begin
        if (drv_done) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      drv_start_q <= 1'b0;
      ack_q       <= '0;
      ack_resp_q  <= RESP_OKAY;
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      to_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      drv_start_q <= drv_start_d;
      ack_q       <= ack_d;
      ack_resp_q  <= ack_resp_d;
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      to_err_q    <= to_err_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign ack_resp  = ack_resp_q;
  assign drv_start = drv_start_q;
  assign m_awaddr  = awaddr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign busy      = (state_q != IDLE);
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
  assign timeout_err = to_err_q;
`endif

endmodule

// File: tb/tb_axi4lite_wr_arbiter.sv
// tb/tb_axi4lite_wr_arbiter.sv - directed self-checking bench for axi4lite_wr_arbiter
module tb_axi4lite_wr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N*DW/8-1:0] req_strb;
  logic [N-1:0]      ack;
  logic [1:0]        ack_resp;
  logic              drv_start;
  logic              drv_done;
  logic [1:0]        drv_bresp;
  logic [AW-1:0]     m_awaddr;
  logic [DW-1:0]     m_wdata;
  logic [DW/8-1:0]   m_wstrb;
  logic              busy;
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  logic [AW-1:0]   exp_addr [N];
  logic [DW-1:0]   exp_data [N];
  logic [DW/8-1:0] exp_strb [N];

  int errors = 0;
  int checks = 0;

  axi4lite_wr_arbiter #(
    .NUM_REQ (N),
    .AW      (AW),
    .DW      (DW)
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_strb  (req_strb),
    .ack       (ack),
    .ack_resp  (ack_resp),
    .drv_start (drv_start),
    .drv_done  (drv_done),
    .drv_bresp (drv_bresp),
    .m_awaddr  (m_awaddr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .busy      (busy)
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
    , .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Waits for drv_start, checks the payload, completes with bresp and checks
  // the ack. req is set to req_after during the ack cycle.
  task automatic serve(input int idx, input logic [1:0] bresp,
                       input logic [N-1:0] req_after, input string tag);
    int n;
    n = 0;
    while (drv_start !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk($sformatf("%s drv_start", tag), drv_start, 1);
    chk($sformatf("%s m_awaddr", tag), m_awaddr, exp_addr[idx]);
    chk($sformatf("%s m_wdata", tag), m_wdata, exp_data[idx]);
    chk($sformatf("%s m_wstrb", tag), m_wstrb, exp_strb[idx]);
    step();
    chk($sformatf("%s drv_start width", tag), drv_start, 0);
    step();
    drv_done  = 1'b1;
    drv_bresp = bresp;
    step();
    drv_done  = 1'b0;
    drv_bresp = 2'b00;
    chk($sformatf("%s ack", tag), ack, 64'(N'(1) << idx));
    chk($sformatf("%s ack_resp", tag), ack_resp, bresp);
    chk($sformatf("%s m_awaddr hold", tag), m_awaddr, exp_addr[idx]);
    req = req_after;
    step();
    chk($sformatf("%s ack width", tag), ack, 0);
  endtask

  initial begin
    int n;
    logic seen;
    int order [5];
    order = '{0, 1, 2, 3, 0};

    exp_addr = '{32'h0000_1000, 32'h0000_0040, 32'h0000_1020, 32'h0000_1030};
    exp_data = '{32'hC0DE_0000, 32'hDEAD_BEEF, 32'hC0DE_0002, 32'hC0DE_0003};
    exp_strb = '{4'h1, 4'hF, 4'h3, 4'hC};
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]     = exp_addr[i];
      req_data[i*DW +: DW]     = exp_data[i];
      req_strb[i*DW/8 +: DW/8] = exp_strb[i];
    end

    rst       = 1'b1;
    req       = '0;
    drv_done  = 1'b0;
    drv_bresp = 2'b00;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst ack", ack, 0);
    chk("rst ack_resp", ack_resp, 0);
    chk("rst drv_start", drv_start, 0);
    chk("rst m_awaddr", m_awaddr, 0);
    chk("rst m_wdata", m_wdata, 0);
    chk("rst m_wstrb", m_wstrb, 0);
    chk("rst busy", busy, 0);
    chk("rst rr_ptr", dut.u_arb.ptr_q, 0);
`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
    chk("rst timeout_err", timeout_err, 0);
`endif

    // single write from requester 1, with start latency
    req = 4'b0010;
    step();
    chk("single start cycle busy", busy, 1);
    chk("single start cycle drv_start", drv_start, 0);
    step();
    chk("single latency drv_start", drv_start, 1);
    serve(1, 2'b00, 4'b0000, "single");
    chk("single busy after", busy, 0);
    chk("single rr_ptr", dut.u_arb.ptr_q, 2);

    // error response, wraps from ptr 2 to requester 0, no retry afterwards
    req = 4'b0001;
    serve(0, 2'b10, 4'b0000, "slverr");
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (drv_start || busy || (ack != 0)) seen = 1'b1;
    end
    chk("slverr no retry", seen, 0);
    chk("slverr rr_ptr", dut.u_arb.ptr_q, 1);

    // withdrawal one cycle after grant
    req = 4'b0100;
    step();
    req = 4'b0000;
    serve(2, 2'b00, 4'b0000, "withdraw");
    chk("withdraw rr_ptr", dut.u_arb.ptr_q, 3);

    // reset while waiting for the driver
    req = 4'b1000;
    n = 0;
    while (drv_start !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk("rstwait drv_start", drv_start, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstwait ack", ack, 0);
    chk("rstwait busy", busy, 0);
    chk("rstwait rr_ptr", dut.u_arb.ptr_q, 0);
    chk("rstwait m_awaddr", m_awaddr, 0);
    serve(3, 2'b00, 4'b0000, "after_rst");
    chk("after_rst rr_ptr", dut.u_arb.ptr_q, 0);

    // drv_done while idle is ignored
    drv_done = 1'b1;
    step();
    drv_done = 1'b0;
    chk("stray done ack", ack, 0);
    chk("stray done busy", busy, 0);
    step();
    chk("stray done ack later", ack, 0);

    // fairness with all requests held
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve(order[k], 2'b00, (k == 4) ? 4'b0000 : 4'b1111,
            $sformatf("fair%0d", k));
    end
    chk("fair rr_ptr", dut.u_arb.ptr_q, 1);

`ifdef AXI4LITE_WR_ARB_TIMEOUT_EN
    // watchdog: no drv_done for 16 wait cycles
    req = 4'b0010;
    n = 0;
    while (drv_start !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk("to drv_start", drv_start, 1);
    req = 4'b1111;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (ack != 0) seen = 1'b1;
    end
    chk("to no early ack", seen, 0);
    step();
    chk("to ack", ack, 4'b0010);
    chk("to ack_resp", ack_resp, 2'b10);
    chk("to timeout_err", timeout_err, 1);
    req = 4'b1101;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (drv_start || (ack != 0) || !busy) seen = 1'b1;
    end
    chk("to drain blocks", seen, 0);
    drv_done = 1'b1;
    step();
    drv_done = 1'b0;
    chk("to drain exit ack", ack, 0);
    chk("to drain exit busy", busy, 0);
    serve(2, 2'b00, 4'b0000, "to_next");
    chk("to sticky", timeout_err, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
